// File: rtl/clk_mux_pkg.sv
// Shared types and helpers for the clock-mux
// enable sequencer.
package clk_mux_pkg;

  localparam int C_MAX_CLOCKS = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OFF,
    ST_ON
  } state_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Indices at or beyond C_MAX_CLOCKS yield an all-zero vector.
  function automatic logic [C_MAX_CLOCKS-1:0] idx2onehot(
    input int unsigned idx
  );
    logic [C_MAX_CLOCKS-1:0] v;
    v = C_MAX_CLOCKS'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/clk_mux_ctrl.sv
// Break-before-make sequencer that drives the
// one-hot enable vector of the safe clock mux.
module clk_mux_ctrl
  import clk_mux_pkg::*;
#(
  parameter int P_NO_CLOCKS     = 4,
  parameter int P_SETTLE_CYCLES = 8,
  parameter int P_RST_CLK_IDX   = 0,
  localparam int P_IDX_W = idx_width(P_NO_CLOCKS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_sel_valid,
  input  logic [P_IDX_W-1:0] clk_sel_idx,
  output logic               clk_sel_ready,
  output logic [P_NO_CLOCKS-1:0] clk_en_vec,
  output logic [P_IDX_W-1:0] cur_clk_idx,
  output logic               switch_done,
  output logic               sel_err
);

  localparam int CW = $clog2(P_SETTLE_CYCLES + 1);

  localparam logic [CW-1:0] C_LOAD =
    CW'(P_SETTLE_CYCLES - 1);

  localparam logic [P_IDX_W-1:0] C_RST_IDX =
    P_IDX_W'(P_RST_CLK_IDX);

  localparam logic [P_NO_CLOCKS-1:0] C_RST_EN =
    P_NO_CLOCKS'(idx2onehot(P_RST_CLK_IDX));

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [P_IDX_W-1:0] pend_idx;
  logic               idx_bad;
  logic               idx_same;

  assign clk_sel_ready = (state == ST_IDLE);

  assign idx_bad =
    32'(clk_sel_idx) >= 32'(P_NO_CLOCKS);

  assign idx_same = (clk_sel_idx == cur_clk_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pend_idx    <= '0;
      clk_en_vec  <= C_RST_EN;
      cur_clk_idx <= C_RST_IDX;
      switch_done <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      switch_done <= 1'b0;
      sel_err     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (clk_sel_valid) begin
            unique case (1'b1)
              idx_bad:  sel_err     <= 1'b1;
              idx_same: switch_done <= 1'b1;
              default: begin
                pend_idx   <= clk_sel_idx;
                clk_en_vec <= '0;
                cnt        <= C_LOAD;
                state      <= ST_OFF;
              end
            endcase
          end
        end
        ST_OFF: begin
          if (cnt == '0) begin
            clk_en_vec <= P_NO_CLOCKS'(
              idx2onehot(32'(pend_idx)));
            cnt   <= C_LOAD;
            state <= ST_ON;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_ON: begin
          if (cnt == '0) begin
            cur_clk_idx <= pend_idx;
            switch_done <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/clk_mux_ctrl.md
Name: clk_mux_ctrl

Overview:
- Control-side sequencer that generates the one-hot clock-enable vector consumed by the parameterized safe clock multiplexer.
- Accepts clock-select requests on a valid/ready handshake and performs a break-before-make switch: all enables low, settle, new enable high, settle, then signal completion.
- Runs on a single system clock.
- Guarantees the mux never sees two enables high and gives each destination-domain double-flop synchronizer time to flush.

Parameters:
- P_NO_CLOCKS, 4: number of selectable clocks; width of clk_en_vec; must be >= 2.
- P_SETTLE_CYCLES, 8: clk cycles held in each of the all-off and new-on phases; must be >= 1; sized to cover 2 cycles of the slowest muxed clock plus margin.
- P_RST_CLK_IDX, 0: clock index enabled out of reset; must be < P_NO_CLOCKS.
- Local constant P_IDX_W = max(1, $clog2(P_NO_CLOCKS)).

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- clk_sel_valid, input, 1: switch request valid.
- clk_sel_idx, input, P_IDX_W: requested clock index.
- clk_sel_ready, output, 1: high when idle and able to accept a request.
- clk_en_vec, output, P_NO_CLOCKS: one-hot (or all-zero) enable to the clock mux; registered.
- cur_clk_idx, output, P_IDX_W: index of the currently active clock; registered.
- switch_done, output, 1: one-cycle pulse when a switch or no-op request completes.
- sel_err, output, 1: one-cycle pulse when a request with index >= P_NO_CLOCKS is accepted.

Behaviour:
- Reset (rst_n low at a clk edge), taking effect regardless of state, including mid-switch:
  - clk_en_vec = 1 << P_RST_CLK_IDX
  - cur_clk_idx = P_RST_CLK_IDX
  - state = IDLE, clk_sel_ready = 1, switch_done = 0, sel_err = 0, counter = 0
- States: IDLE, OFF, ON.
- clk_sel_ready = (state == IDLE); combinational from the state register. A request is accepted on an edge where clk_sel_valid && clk_sel_ready.
- In IDLE, on an accepted request:
  - idx >= P_NO_CLOCKS: sel_err pulses the next cycle. No change to clk_en_vec or cur_clk_idx. Stay IDLE.
  - idx == cur_clk_idx: switch_done pulses the next cycle. No change to clk_en_vec. Stay IDLE.
  - Otherwise: latch idx into pend_idx, clk_en_vec <= 0, counter <= P_SETTLE_CYCLES-1, go to OFF.
- In OFF:
  - counter decrements each cycle.
  - At counter == 0: clk_en_vec <= 1 << pend_idx, counter <= P_SETTLE_CYCLES-1, go to ON.
- In ON:
  - counter decrements each cycle.
  - At counter == 0: cur_clk_idx <= pend_idx, switch_done pulses, go to IDLE.
- Timing, with acceptance edge = cycle 0 (S = P_SETTLE_CYCLES):
  - clk_en_vec is all-zero in cycles 1..S.
  - The new one-hot appears in cycle S+1.
  - switch_done and clk_sel_ready are high in cycle 2S+1.
  - Total latency is 2S+1 cycles.
- Requests presented while not ready are neither accepted nor queued. The requester holds valid until ready.
- Invariant: popcount(clk_en_vec) <= 1 in every cycle. A transition from one set bit to a different set bit never occurs without at least S intervening all-zero cycles.
- switch_done and sel_err are never high in the same cycle.
- Back-to-back: a request accepted in the same cycle as switch_done is legal.

Decomposition:
- Shared package clk_mux_pkg holds:
  - the state enum (IDLE/OFF/ON)
  - a function idx2onehot(idx) returning the P_NO_CLOCKS-wide vector
  - a function for P_IDX_W
- The settle counter is inline, $clog2(P_SETTLE_CYCLES+1) bits.
- No sub-module; the FSM plus counter is one module. Integration pairs one clk_mux_ctrl with one clk_mux instance.

Test Plan:
- Reset defaults: P_RST_CLK_IDX=0, assert rst_n low for 3 cycles, then release -> clk_en_vec=4'b0001, cur_clk_idx=0, clk_sel_ready=1, no pulses.
- Normal switch, S=4: request idx 2 at cycle 0 -> clk_en_vec=0 in cycles 1-4, 4'b0100 from cycle 5, switch_done pulse and cur_clk_idx=2 at cycle 9, ready low in cycles 1-8.
- Same-index and invalid-index requests:
  - Request idx 2 while on 2 -> switch_done pulse at cycle 1, clk_en_vec unchanged.
  - P_NO_CLOCKS=3, request idx 3 -> sel_err pulse at cycle 1, no state change.
- Busy and back-to-back requests:
  - Hold valid with idx 1 during a switch to 3 -> accepted only in the done cycle.
  - Then zero cycles follow, then 4'b0010. No overlap of 4'b1000 and 4'b0010 in any cycle.
- Reset mid-operation: assert rst_n low while in OFF (clk_en_vec=0) -> next cycle clk_en_vec=4'b0001, cur_clk_idx=0, no switch_done.
- Random-request soak, 10k cycles, with an assertion monitor -> popcount(clk_en_vec) <= 1 always, and >= S zero cycles between differing one-hot values.
